// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants, CRC-32 parameters and transmitter state encoding.
package eth_pkg;

   localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
   localparam logic [7:0]  ETH_SFD         = 8'hD5;
   localparam int          ETH_MIN_FRAME   = 60;
   localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_SFD,
      ST_DATA,
      ST_PAD,
      ST_FCS,
      ST_IFG
   } eth_tx_state_t;

   // Dibit idx of a byte, LSB pair first as RMII puts it on the wire.
   function automatic logic [1:0] dibit_of(input logic [7:0] b, input logic [1:0] idx);
      case (idx)
         2'd0:    return b[1:0];
         2'd1:    return b[3:2];
         2'd2:    return b[5:4];
         default: return b[7:6];
      endcase
   endfunction

endpackage

// File: rtl/eth_crc32_2b.sv
// Combinational CRC-32 (reflected) advance by one RMII dibit, d[0] processed first.
module eth_crc32_2b
   import eth_pkg::*;
(
   input  logic [31:0] crc,
   input  logic [1:0]  d,
   output logic [31:0] crc_next
);

   always_comb begin
      crc_next = crc;
      // NOTE: blocking assignments here chain the two bit steps inside one evaluation.
      for (int i = 0; i < 2; i++) begin
         if (crc_next[0] ^ d[i])
            crc_next = (crc_next >> 1) ^ ETH_CRC_POLY;
         else
            crc_next = crc_next >> 1;
      end
   end

endmodule

// File: rtl/eth_rmii_tx.sv
// RMII transmitter: byte stream in, preamble/SFD/data/pad/FCS out on TXD[1:0]/TX_EN,
// followed by an enforced inter-frame gap.
module eth_rmii_tx
   import eth_pkg::*;
#(
   parameter bit PAD       = 1'b1,
   parameter int IFG_BYTES = 12
) (
   input  logic       clk50,
   input  logic       reset_n,
   input  logic [7:0] data,
   input  logic       valid,
   input  logic       eop,
   output logic       ready,
   output logic [1:0] tx,
   output logic       txen,
   output logic       busy,
   output logic       underrun
);

   localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES * 4 - 1);
   localparam logic [10:0] MIN_LEN  = 11'(ETH_MIN_FRAME);

   eth_tx_state_t state, state_nx;
   logic [1:0]    dib, dib_nx;
   logic [2:0]    cnt, cnt_nx;
   logic [10:0]   byte_cnt, byte_cnt_nx, byte_inc;
   logic [7:0]    sh, sh_nx;
   logic          last, last_nx;
   logic [31:0]   crc, crc_nx, crc_upd;
   logic [15:0]   ifg_cnt, ifg_cnt_nx;
   logic [1:0]    tx_nx;
   logic          txen_nx, underrun_nx, start;

   // The CRC follows exactly what is on the wire, so it is fed from the tx register.
   eth_crc32_2b u_crc (
      .crc      (crc),
      .d        (tx),
      .crc_next (crc_upd)
   );

   assign byte_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
   assign busy     = (state != ST_IDLE);
   assign ready    = (dib == 2'd3) && ((state == ST_SFD) || (state == ST_DATA && !last));

   always_comb begin
      // NOTE: every next-value is defaulted before the case so no latch can be inferred.
      state_nx    = state;
      dib_nx      = dib + 2'd1;
      cnt_nx      = cnt;
      byte_cnt_nx = byte_cnt;
      sh_nx       = sh;
      last_nx     = last;
      crc_nx      = crc;
      ifg_cnt_nx  = ifg_cnt;
      txen_nx     = txen;
      underrun_nx = 1'b0;
      tx_nx       = 2'b00;
      start       = 1'b0;

      case (state)
         ST_IDLE: begin
            dib_nx = 2'd0;
            start  = valid;
         end
         ST_PRE: begin
            crc_nx = ETH_CRC_INIT;
            if (dib == 2'd3) begin
               if (cnt == 3'd6) begin
                  state_nx = ST_SFD;
                  sh_nx    = ETH_SFD;
               end else begin
                  cnt_nx = cnt + 3'd1;
               end
            end
         end
         ST_SFD, ST_DATA: begin
            if (state == ST_DATA) crc_nx = crc_upd;
            if (dib == 2'd3) begin
               if (ready && valid) begin
                  state_nx    = ST_DATA;
                  sh_nx       = data;
                  last_nx     = eop;
                  byte_cnt_nx = byte_inc;
               end else if (ready) begin
                  // Source starved mid-frame: abort without FCS.
                  state_nx    = ST_IFG;
                  txen_nx     = 1'b0;
                  underrun_nx = 1'b1;
                  ifg_cnt_nx  = '0;
               end else if (PAD && byte_cnt < MIN_LEN) begin
                  state_nx    = ST_PAD;
                  sh_nx       = 8'h00;
                  byte_cnt_nx = byte_inc;
               end else begin
                  state_nx = ST_FCS;
                  cnt_nx   = '0;
                  crc_nx   = ~crc_upd;
               end
            end
         end
         ST_PAD: begin
            crc_nx = crc_upd;
            if (dib == 2'd3) begin
               if (byte_cnt < MIN_LEN) begin
                  byte_cnt_nx = byte_inc;
               end else begin
                  state_nx = ST_FCS;
                  cnt_nx   = '0;
                  crc_nx   = ~crc_upd;
               end
            end
         end
         ST_FCS: begin
            // crc holds the inverted FCS and is shifted out two bits per cycle.
            crc_nx = crc >> 2;
            if (dib == 2'd3) begin
               if (cnt == 3'd3) begin
                  state_nx   = ST_IFG;
                  txen_nx    = 1'b0;
                  ifg_cnt_nx = '0;
               end else begin
                  cnt_nx = cnt + 3'd1;
               end
            end
         end
         ST_IFG: begin
            dib_nx     = 2'd0;
            ifg_cnt_nx = ifg_cnt + 16'd1;
            if (ifg_cnt == IFG_LAST) begin
               start = valid;
               if (!valid) state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase

      if (start) begin
         state_nx    = ST_PRE;
         dib_nx      = 2'd0;
         cnt_nx      = '0;
         byte_cnt_nx = '0;
         sh_nx       = ETH_PREAMBLE;
         last_nx     = 1'b0;
         txen_nx     = 1'b1;
      end

      if (!txen_nx)
         tx_nx = 2'b00;
      else if (state_nx == ST_FCS)
         tx_nx = crc_nx[1:0];
      else
         tx_nx = dibit_of(sh_nx, dib_nx);
   end

   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         dib      <= '0;
         cnt      <= '0;
         byte_cnt <= '0;
         sh       <= '0;
         last     <= 1'b0;
         crc      <= '0;
         ifg_cnt  <= '0;
         tx       <= 2'b00;
         txen     <= 1'b0;
         underrun <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         state    <= state_nx;
         dib      <= dib_nx;
         cnt      <= cnt_nx;
         byte_cnt <= byte_cnt_nx;
         sh       <= sh_nx;
         last     <= last_nx;
         crc      <= crc_nx;
         ifg_cnt  <= ifg_cnt_nx;
         tx       <= tx_nx;
         txen     <= txen_nx;
         underrun <= underrun_nx;
      end
   end

endmodule
